// File: rtl/bram_load_sequencer_pkg.sv
// bram_load_sequencer_pkg: shared FSM state, section indices, default sizes and
// the next-nonzero-section search used by the load sequencer.
package bram_load_sequencer_pkg;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_ADVANCE, S_FINISH} state_t;

    localparam int SEC_COL_IDX   = 0;
    localparam int SEC_VALUE     = 1;
    localparam int SEC_NODE_INFO = 2;
    localparam int SEC_WEIGHT    = 3;
    localparam int SEC_A         = 4;

    localparam int DEF_NUM_SEC = 5;
    localparam int DEF_ADDR_W  = 18;
    localparam int MAX_SEC     = 32;

    // Lowest set bit of nz at or above index from; MAX_SEC when there is none.
    function automatic logic [5:0] next_nz(input logic [MAX_SEC-1:0] nz, input logic [5:0] from);
        next_nz = 6'(MAX_SEC);
        for (int i = MAX_SEC - 1; i >= 0; i--)
            if (nz[i] && 6'(i) >= from)
                next_nz = 6'(i);
    endfunction

endpackage

// File: rtl/bram_load_sequencer.sv
// bram_load_sequencer: streams host words into NUM_SEC BRAMs in section order.
// Optional LOAD_CHECKSUM_EN adds a 16-bit running sum of accepted words.
module bram_load_sequencer
    import bram_load_sequencer_pkg::*;
#(
    parameter int LOAD_W  = 32,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int NUM_SEC = DEF_NUM_SEC
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [NUM_SEC*ADDR_W-1:0] sec_len,
    input  logic [LOAD_W-1:0]         s_data,
    input  logic                      s_valid,
    output logic                      s_ready,
    output logic [LOAD_W-1:0]         bram_din,
    output logic [ADDR_W-1:0]         bram_addra,
    output logic [NUM_SEC-1:0]        bram_ena,
    output logic [NUM_SEC-1:0]        load_done,
    output logic                      busy,
`ifdef LOAD_CHECKSUM_EN
    output logic [15:0]               checksum,
`endif
    output logic                      all_done
);

    localparam int SW = $clog2(NUM_SEC + 1);
    localparam int NS = 2 ** SW;

    state_t              r_state, w_state_nxt;
    logic [SW-1:0]       r_sec;
    logic [ADDR_W-1:0]   r_len [NS];
    logic [ADDR_W-1:0]   r_cnt;
    logic [LOAD_W-1:0]   r_din;
    logic [ADDR_W-1:0]   r_addr;
    logic [NUM_SEC-1:0]  r_ena;
    logic [NUM_SEC-1:0]  r_done;
    logic                r_all;
    logic [MAX_SEC-1:0]  w_nz_in, w_nz_lat;
    logic [5:0]          w_first, w_next;
    logic [NUM_SEC-1:0]  w_skip, w_adv, w_onehot;
    logic                w_accept, w_last;

    always_comb begin
        w_nz_in  = '0;
        w_nz_lat = '0;
        for (int i = 0; i < NUM_SEC; i++) begin
            w_nz_in[i]  = |sec_len[i*ADDR_W +: ADDR_W];
            w_nz_lat[i] = |r_len[i];
        end
    end

    assign w_first = next_nz(w_nz_in, 6'd0);
    assign w_next  = next_nz(w_nz_lat, 6'(r_sec) + 6'd1);

    // Zero-length sections skipped over are reported done alongside their neighbour.
    always_comb begin
        w_skip = '0;
        w_adv  = '0;
        for (int i = 0; i < NUM_SEC; i++) begin
            w_skip[i] = 6'(i) < w_first;
            w_adv[i]  = 6'(i) >= 6'(r_sec) && 6'(i) < w_next;
        end
    end

    assign w_onehot = NUM_SEC'(1) << r_sec;
    assign w_accept = s_valid && r_state == S_LOAD;
    assign w_last   = r_cnt == r_len[r_sec] - ADDR_W'(1);

    always_ff @(posedge clk or posedge rst)
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;

    always_comb begin
        w_state_nxt = r_state;
        s_ready     = 1'b0;
        busy        = 1'b1;
        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (start)
                    w_state_nxt = (w_first >= 6'(NUM_SEC)) ? S_FINISH : S_LOAD;
            end
            S_LOAD: begin
                s_ready = 1'b1;
                if (w_accept && w_last)
                    w_state_nxt = S_ADVANCE;
            end
            S_ADVANCE: w_state_nxt = (w_next >= 6'(NUM_SEC)) ? S_FINISH : S_LOAD;
            S_FINISH:  w_state_nxt = S_IDLE;
            default:   w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sec  <= '0;
            r_cnt  <= '0;
            r_din  <= '0;
            r_addr <= '0;
            r_ena  <= '0;
            r_done <= '0;
            r_all  <= 1'b0;
            for (int i = 0; i < NS; i++)
                r_len[i] <= '0;
        end else begin
            r_ena <= '0;
            if (w_accept) begin
                r_din  <= s_data;
                r_addr <= r_cnt;
                r_ena  <= w_onehot;
                r_cnt  <= w_last ? '0 : r_cnt + ADDR_W'(1);
            end
            case (r_state)
                S_IDLE: if (start) begin
                    for (int i = 0; i < NUM_SEC; i++)
                        r_len[i] <= sec_len[i*ADDR_W +: ADDR_W];
                    r_done <= w_skip;
                    r_all  <= 1'b0;
                    r_sec  <= SW'(w_first);
                    r_cnt  <= '0;
                end
                S_ADVANCE: begin
                    r_done <= r_done | w_adv;
                    r_sec  <= SW'(w_next);
                end
                S_FINISH: r_all <= 1'b1;
                default: ;
            endcase
        end
    end

`ifdef LOAD_CHECKSUM_EN
    logic [15:0] r_csum;
    always_ff @(posedge clk or posedge rst)
        if (rst)                          r_csum <= '0;
        else if (r_state == S_IDLE && start) r_csum <= '0;
        else if (w_accept)                r_csum <= r_csum + s_data[15:0];
    assign checksum = r_csum;
`endif

    assign bram_din   = r_din;
    assign bram_addra = r_addr;
    assign bram_ena   = r_ena;
    assign load_done  = r_done;
    assign all_done   = r_all;

endmodule

// File: tb/tb_bram_load_sequencer.sv
// tb_bram_load_sequencer: directed table-driven bench for bram_load_sequencer.
// Define LOAD_CHECKSUM_EN for both files to exercise the checksum output.
module tb_bram_load_sequencer;
    import bram_load_sequencer_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [89:0] sec_len = '0;
    logic [31:0] s_data = '0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [31:0] bram_din;
    logic [17:0] bram_addra;
    logic [4:0]  bram_ena;
    logic [4:0]  load_done;
    logic        busy;
    logic        all_done;
`ifdef LOAD_CHECKSUM_EN
    logic [15:0] checksum;
`endif

    bram_load_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .sec_len(sec_len),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .bram_din(bram_din), .bram_addra(bram_addra), .bram_ena(bram_ena),
        .load_done(load_done), .busy(busy),
`ifdef LOAD_CHECKSUM_EN
        .checksum(checksum),
`endif
        .all_done(all_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  ena;
        logic [17:0] addr;
        logic [31:0] din;
        int          cyc;
    } ev_t;

    typedef struct {
        int          sc;
        logic [4:0]  ena;
        logic [17:0] addr;
        int          word;
    } vec_t;

    localparam logic [31:0] BASE = 32'hA500_0000;

    ev_t  evq[$];
    vec_t vecs[14];
    int   rise[5];
    int   bad_ena, node_seen, n_pass, n_total;
    bit   timed_out, cs_mode;

    function automatic logic [4:0] oh(input int s);
        return 5'(1) << s;
    endfunction

    function automatic logic [89:0] pack(input int l0, l1, l2, l3, l4);
        return {18'(l4), 18'(l3), 18'(l2), 18'(l1), 18'(l0)};
    endfunction

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic run_stream(input logic [89:0] lens, input bit toggle, input int inject_at, input int abort_node);
        int   c;
        int   n_acc;
        bit   prev_acc;
        logic [4:0] prev_done;
        evq.delete();
        foreach (rise[k]) rise[k] = -1;
        bad_ena = 0; node_seen = 0; n_acc = 0; prev_acc = 1'b0;
        @(negedge clk);
        sec_len = lens; start = 1'b1; s_valid = 1'b0;
        @(negedge clk);
        start = 1'b0;
        prev_done = load_done;
        for (c = 0; c < 300; c++) begin
            if (bram_ena != 5'd0) begin
                evq.push_back('{bram_ena, bram_addra, bram_din, c});
                if (bram_ena == oh(SEC_NODE_INFO)) node_seen++;
            end
            if ((bram_ena != 5'd0) != prev_acc) bad_ena++;
            for (int k = 0; k < 5; k++)
                if (load_done[k] && !prev_done[k]) rise[k] = c;
            prev_done = load_done;
            if (prev_acc) n_acc++;
            if (all_done || (abort_node > 0 && node_seen >= abort_node)) break;
            s_valid = toggle ? c[0] : 1'b1;
            s_data  = cs_mode ? (n_acc == 0 ? 32'h0000_FFFF : 32'h0000_0002) : BASE + 32'(n_acc);
            start   = (c == inject_at);
            if (c == inject_at) sec_len = pack(1, 1, 1, 1, 1);
            prev_acc = s_valid && s_ready;
            @(negedge clk);
        end
        timed_out = (c >= 300);
        s_valid = 1'b0;
        start = 1'b0;
        check("no_timeout", 64'(timed_out), 64'(0));
    endtask

    task automatic cmp_events(input int sc, input string nm);
        int j = 0;
        foreach (vecs[i]) if (vecs[i].sc == sc) begin
            if (j < evq.size())
                check($sformatf("%s_ev%0d", nm, j),
                      64'({evq[j].ena, evq[j].addr, evq[j].din}),
                      64'({vecs[i].ena, vecs[i].addr, BASE + 32'(vecs[i].word)}));
            j++;
        end
        check({nm, "_count"}, 64'(evq.size()), 64'(j));
        check({nm, "_ena_follows_accept"}, 64'(bad_ena), 64'(0));
    endtask

    task automatic check_zero(input string nm);
        check({nm, "_s_ready"}, 64'(s_ready), 64'(0));
        check({nm, "_ena"}, 64'(bram_ena), 64'(0));
        check({nm, "_din"}, 64'(bram_din), 64'(0));
        check({nm, "_addra"}, 64'(bram_addra), 64'(0));
        check({nm, "_load_done"}, 64'(load_done), 64'(0));
        check({nm, "_busy"}, 64'(busy), 64'(0));
        check({nm, "_all_done"}, 64'(all_done), 64'(0));
    endtask

    task automatic check_final(input string nm);
        check({nm, "_all_done"}, 64'(all_done), 64'(1));
        check({nm, "_load_done"}, 64'(load_done), 64'h1f);
        check({nm, "_busy"}, 64'(busy), 64'(0));
    endtask

    initial begin
        int last_idx[5];
        last_idx = '{1, 2, 5, 7, 8};
        vecs = '{
            '{1, oh(SEC_COL_IDX),   18'd0, 0},
            '{1, oh(SEC_COL_IDX),   18'd1, 1},
            '{1, oh(SEC_VALUE),     18'd0, 2},
            '{1, oh(SEC_NODE_INFO), 18'd0, 3},
            '{1, oh(SEC_NODE_INFO), 18'd1, 4},
            '{1, oh(SEC_NODE_INFO), 18'd2, 5},
            '{1, oh(SEC_WEIGHT),    18'd0, 6},
            '{1, oh(SEC_WEIGHT),    18'd1, 7},
            '{1, oh(SEC_A),         18'd0, 8},
            '{2, oh(SEC_COL_IDX),   18'd0, 0},
            '{2, oh(SEC_COL_IDX),   18'd1, 1},
            '{2, oh(SEC_NODE_INFO), 18'd0, 2},
            '{2, oh(SEC_WEIGHT),    18'd0, 3},
            '{2, oh(SEC_A),         18'd0, 4}
        };
        n_pass = 0; n_total = 0; cs_mode = 1'b0;

        repeat (2) @(negedge clk);
        check_zero("reset");
        rst = 1'b0;

        run_stream(pack(2, 1, 3, 2, 1), 1'b0, -1, 0);
        cmp_events(1, "cont");
        if (evq.size() == 9)
            for (int k = 0; k < 5; k++)
                check($sformatf("cont_done_rise%0d", k), 64'(rise[k]), 64'(evq[last_idx[k]].cyc + 1));
        check_final("cont");

        run_stream(pack(2, 0, 1, 1, 1), 1'b0, -1, 0);
        cmp_events(2, "zero_len");
        check("zero_len_value_done_with_col", 64'(rise[SEC_VALUE]), 64'(rise[SEC_COL_IDX]));
        if (evq.size() == 5)
            check("zero_len_col_rise", 64'(rise[SEC_COL_IDX]), 64'(evq[1].cyc + 1));
        check_final("zero_len");

        run_stream(pack(2, 1, 3, 2, 1), 1'b1, -1, 0);
        cmp_events(1, "toggle");
        check_final("toggle");

        run_stream(pack(2, 1, 3, 2, 1), 1'b0, 4, 0);
        cmp_events(1, "busy_start");
        check_final("busy_start");

        run_stream(pack(2, 1, 4, 2, 1), 1'b0, -1, 3);
        check("abort_node_words", 64'(node_seen), 64'(3));
        rst = 1'b1;
        @(negedge clk);
        check_zero("mid_reset");
        rst = 1'b0;
        run_stream(pack(2, 1, 3, 2, 1), 1'b0, -1, 0);
        cmp_events(1, "after_reset");
        check_final("after_reset");

`ifdef LOAD_CHECKSUM_EN
        cs_mode = 1'b1;
        run_stream(pack(1, 1, 0, 0, 0), 1'b0, -1, 0);
        check("checksum", 64'(checksum), 64'h0001);
        check("checksum_all_done", 64'(all_done), 64'(1));
        cs_mode = 1'b0;
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
